// File: rtl/tmds_video_sequencer.sv
// Raster timing controller for a three-channel TMDS output.
// Counts pixels/lines, fetches pixels from the renderer with a fixed read
// latency, and presents aligned video data, DVI control data and video enable
// to the R/G/B encoders. Everything runs on pixclk; no back-pressure.
module tmds_video_sequencer #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PIX_LAT  = 2
) (
  input  logic       pixclk,
  input  logic       rst,
  input  logic       en,
  output logic       pix_req,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  input  logic [7:0] pix_r,
  input  logic [7:0] pix_g,
  input  logic [7:0] pix_b,
  output logic [7:0] vd_r,
  output logic [7:0] vd_g,
  output logic [7:0] vd_b,
  output logic [1:0] cd_r,
  output logic [1:0] cd_g,
  output logic [1:0] cd_b,
  output logic       vde,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // Fetch register plus PIX_LAT renderer cycles: side-band must be this deep
  // to line up with the returning pixel data.
  localparam int STAGES  = PIX_LAT + 1;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  // Side-band travelling with each pipeline slot; syncs stored as "asserted"
  // flags and converted to line polarity only at the output register.
  typedef struct packed {
    logic hs;
    logic vs;
    logic fst;
  } tag_t;

  logic [9:0] hcnt, vcnt;
  logic       act0;
  tag_t       tag0;

  logic [STAGES:1] vld_pipe;
  tag_t [STAGES:1] tag_pipe;

  // Raster counters; held at the origin while disabled so a restart begins
  // at (0,0) in the first enabled cycle.
  always_ff @(posedge pixclk) begin
    if (rst || !en) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == H_LAST) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_LAST) ? 10'd0 : vcnt + 10'd1;
    end else begin
      hcnt <= hcnt + 10'd1;
    end
  end

  // Decode the current raster position; a disabled raster injects idle slots.
  always_comb begin
    act0     = en && (hcnt < H_ACT) && (vcnt < V_ACT);
    tag0.hs  = en && (hcnt >= HS_START) && (hcnt < HS_END);
    tag0.vs  = en && (vcnt >= VS_START) && (vcnt < VS_END);
    tag0.fst = en && (hcnt == 10'd0) && (vcnt == 10'd0);
  end

  // Valid / side-band delay line; stage 1 doubles as the fetch strobe.
  always_ff @(posedge pixclk) begin
    if (rst) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], act0};
      tag_pipe <= {tag_pipe[STAGES-1:1], tag0};
    end
  end

  assign pix_req = vld_pipe[1];

  // Fetch address; only moves on real requests so it holds during blanking.
  always_ff @(posedge pixclk) begin
    if (rst) begin
      pix_x <= '0;
      pix_y <= '0;
    end else if (act0) begin
      pix_x <= hcnt;
      pix_y <= vcnt;
    end
  end

  // Encoder-facing register: pixel data in the active region, DVI control
  // symbols otherwise. Control data is frozen while video is enabled.
  always_ff @(posedge pixclk) begin
    if (rst) begin
      vde         <= 1'b0;
      vd_r        <= '0;
      vd_g        <= '0;
      vd_b        <= '0;
      cd_r        <= 2'b00;
      cd_g        <= 2'b00;
      cd_b        <= {~VS_POL, ~HS_POL};
      frame_start <= 1'b0;
    end else begin
      vde         <= vld_pipe[STAGES];
      frame_start <= vld_pipe[STAGES] && tag_pipe[STAGES].fst;
      if (vld_pipe[STAGES]) begin
        vd_r <= pix_r;
        vd_g <= pix_g;
        vd_b <= pix_b;
      end else begin
        vd_r <= '0;
        vd_g <= '0;
        vd_b <= '0;
        cd_r <= 2'b00;
        cd_g <= 2'b00;
        cd_b <= {tag_pipe[STAGES].vs ? VS_POL : ~VS_POL,
                 tag_pipe[STAGES].hs ? HS_POL : ~HS_POL};
      end
    end
  end

endmodule
